// File: rtl/onehot_bank_pkg.sv
// rtl/onehot_bank_pkg.sv - shared sizes and select classification for the one-hot register bank
package onehot_bank_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  // Classification of a write-select vector by how many bits are set.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_kind_t;

endpackage

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - combinational validator and lowest-bit encoder for a one-hot select
module onehot_check
  import onehot_bank_pkg::*;
(
  input  logic [DEPTH-1:0] wsel,
  output sel_kind_t        kind,
  output logic [AW-1:0]    idx
);

  logic multi;
  logic found;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  always_comb begin
    multi = |(wsel & (wsel - DEPTH'(1)));
  end

  // Priority-encode the lowest set bit; for a legal one-hot this is the write target.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wsel[i] && !found) begin
        idx   = AW'(i);
        found = 1'b1;
      end
    end
  end

  // Map the bit count to NONE / ONE / MULTI.
  always_comb begin
    if (wsel == '0) begin
      kind = SEL_NONE;
    end else if (multi) begin
      kind = SEL_MULTI;
    end else begin
      kind = SEL_ONE;
    end
  end

endmodule

// File: rtl/onehot_reg_bank.sv
// rtl/onehot_reg_bank.sv - 32-entry register bank written through a validated one-hot select
module onehot_reg_bank
  import onehot_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             err_multi,
  output logic [AW-1:0]    err_idx,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sel_kind_t        kind;
  logic [AW-1:0]    sel_idx;
  logic             wr_one;
  logic             wr_multi;
  logic             bypass;
  logic [WIDTH-1:0] read_value;

  logic [WIDTH-1:0] mem [DEPTH];

  onehot_check u_check (
    .wsel (wsel),
    .kind (kind),
    .idx  (sel_idx)
  );

  // Decode the classification into write strobes and resolve the write-first read path.
  always_comb begin
    wr_one     = (kind == SEL_ONE);
    wr_multi   = (kind == SEL_MULTI);
    bypass     = wr_one && (sel_idx == raddr);
    read_value = bypass ? wdata : mem[raddr];
  end

  // Storage: only a legal single-bit select writes; multi-hot selects are dropped entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_one) begin
      mem[sel_idx] <= wdata;
    end
  end

  // Registered read port; rdata holds its last value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= read_value;
      end
    end
  end

  // Sticky error capture: the first multi-hot index is kept until cleared, and a
  // multi-hot arriving alongside a clear re-arms with the new index.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi <= 1'b0;
      err_idx   <= '0;
    end else if (wr_multi && (!err_multi || err_clr)) begin
      err_multi <= 1'b1;
      err_idx   <= sel_idx;
    end else if (err_clr) begin
      err_multi <= 1'b0;
      err_idx   <= '0;
    end
  end

  // Accepted-write counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (wr_one && (wr_cnt != CNT_MAX)) begin
      wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

endmodule
